// File: rtl/four_bit_tdm_demux.sv
// ----------------------------------------------------------------------------
// four_bit_tdm_demux
// Receive end of a 2:1 time-multiplexed link. Each valid word carries a
// channel tag. The word is steered to a per-channel holding register. A
// channel-0 word is paired with the channel-1 word that follows it. Completed
// pairs are presented as one {ch1, ch0} word and counted. All outputs are
// registered, so the latency from In to any output is one clock.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   In           link data word (WIDTH)
//   In_valid     qualifies In/Select this cycle
//   Select       channel tag (0 -> ch0, 1 -> ch1)
//   Out_0/Out_1  last word held for each channel (WIDTH)
//   Out_0_valid  1-cycle pulse when Out_0 is updated
//   Out_1_valid  1-cycle pulse when Out_1 is updated
//   Pair_out     {ch1, ch0} of the last completed pair (2*WIDTH)
//   Pair_valid   1-cycle pulse when Pair_out is updated
//   Pair_count   completed pairs, modulo 2**CNT_W (wraps silently)
//   Seq_error    1-cycle pulse when a tag arrives out of order
// ----------------------------------------------------------------------------
module four_bit_tdm_demux #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     In,
    input  logic                 In_valid,
    input  logic                 Select,
    output logic [WIDTH-1:0]     Out_0,
    output logic [WIDTH-1:0]     Out_1,
    output logic                 Out_0_valid,
    output logic                 Out_1_valid,
    output logic [2*WIDTH-1:0]   Pair_out,
    output logic                 Pair_valid,
    output logic [CNT_W-1:0]     Pair_count,
    output logic                 Seq_error
);

    typedef enum logic {
        WAIT_0 = 1'b0,
        WAIT_1 = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   out_0_d;
    logic [WIDTH-1:0]   out_1_d;
    logic               out_0_valid_d;
    logic               out_1_valid_d;
    logic [2*WIDTH-1:0] pair_out_d;
    logic               pair_valid_d;
    logic [CNT_W-1:0]   pair_count_d;
    logic               seq_error_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_0;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a ch0 word always leaves us expecting ch1; a ch1 word
    // always returns us to expecting ch0. Out-of-order tags keep the state.
    always_comb begin
        state_next = state;
        if (In_valid) begin
            if (!Select) begin
                state_next = WAIT_1;
            end else begin
                state_next = WAIT_0;
            end
        end
    end

    // Next values of the output registers
    always_comb begin
        out_0_d       = Out_0;
        out_1_d       = Out_1;
        out_0_valid_d = 1'b0;
        out_1_valid_d = 1'b0;
        pair_out_d    = Pair_out;
        pair_valid_d  = 1'b0;
        pair_count_d  = Pair_count;
        seq_error_d   = 1'b0;
        if (In_valid) begin
            if (!Select) begin
                // A repeated ch0 word replaces the pending one.
                out_0_d       = In;
                out_0_valid_d = 1'b1;
                seq_error_d   = (state == WAIT_1);
            end else begin
                out_1_d       = In;
                out_1_valid_d = 1'b1;
                if (state == WAIT_1) begin
                    // Out_0 still holds the pending ch0 word here.
                    pair_out_d   = {In, Out_0};
                    pair_valid_d = 1'b1;
                    pair_count_d = Pair_count + CNT_W'(1);
                end else begin
                    seq_error_d = 1'b1;
                end
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            Out_0       <= '0;
            Out_1       <= '0;
            Out_0_valid <= 1'b0;
            Out_1_valid <= 1'b0;
            Pair_out    <= '0;
            Pair_valid  <= 1'b0;
            Pair_count  <= '0;
            Seq_error   <= 1'b0;
        end else begin
            Out_0       <= out_0_d;
            Out_1       <= out_1_d;
            Out_0_valid <= out_0_valid_d;
            Out_1_valid <= out_1_valid_d;
            Pair_out    <= pair_out_d;
            Pair_valid  <= pair_valid_d;
            Pair_count  <= pair_count_d;
            Seq_error   <= seq_error_d;
        end
    end

endmodule

// File: tb/tb_four_bit_tdm_demux.sv
// ----------------------------------------------------------------------------
// tb_four_bit_tdm_demux
// Scoreboard bench: each driven cycle pushes the expected output set from a
// behavioural model; one clock later the entry is popped and compared.
// ----------------------------------------------------------------------------
module tb_four_bit_tdm_demux;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic [WIDTH-1:0]   out_0;
        logic [WIDTH-1:0]   out_1;
        logic               out_0_valid;
        logic               out_1_valid;
        logic [2*WIDTH-1:0] pair_out;
        logic               pair_valid;
        logic [CNT_W-1:0]   pair_count;
        logic               seq_error;
    } exp_t;

    logic               clk;
    logic               rst;
    logic [WIDTH-1:0]   in_word;
    logic               in_valid;
    logic               sel;
    logic [WIDTH-1:0]   out_0;
    logic [WIDTH-1:0]   out_1;
    logic               out_0_valid;
    logic               out_1_valid;
    logic [2*WIDTH-1:0] pair_out;
    logic               pair_valid;
    logic [CNT_W-1:0]   pair_count;
    logic               seq_error;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];

    // Reference model state
    logic               m_wait_1;
    logic [WIDTH-1:0]   m_out_0;
    logic [WIDTH-1:0]   m_out_1;
    logic [2*WIDTH-1:0] m_pair;
    logic [CNT_W-1:0]   m_cnt;

    four_bit_tdm_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .In          (in_word),
        .In_valid    (in_valid),
        .Select      (sel),
        .Out_0       (out_0),
        .Out_1       (out_1),
        .Out_0_valid (out_0_valid),
        .Out_1_valid (out_1_valid),
        .Pair_out    (pair_out),
        .Pair_valid  (pair_valid),
        .Pair_count  (pair_count),
        .Seq_error   (seq_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, model it, then compare one clock later.
    task automatic step(input logic r, input logic v, input logic s, input logic [WIDTH-1:0] d);
        exp_t e;
        exp_t got;
        rst      = r;
        in_valid = v;
        sel      = s;
        in_word  = d;
        e = '0;
        if (r) begin
            m_wait_1 = 1'b0;
            m_out_0  = '0;
            m_out_1  = '0;
            m_pair   = '0;
            m_cnt    = '0;
        end else if (v) begin
            if (!s) begin
                e.seq_error   = m_wait_1;
                e.out_0_valid = 1'b1;
                m_out_0       = d;
                m_wait_1      = 1'b1;
            end else begin
                e.out_1_valid = 1'b1;
                m_out_1       = d;
                if (m_wait_1) begin
                    m_pair       = {d, m_out_0};
                    e.pair_valid = 1'b1;
                    m_cnt        = m_cnt + 4'd1;
                end else begin
                    e.seq_error = 1'b1;
                end
                m_wait_1 = 1'b0;
            end
        end
        e.out_0      = m_out_0;
        e.out_1      = m_out_1;
        e.pair_out   = m_pair;
        e.pair_count = m_cnt;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            check("out_0",       32'(out_0),       32'(got.out_0));
            check("out_1",       32'(out_1),       32'(got.out_1));
            check("out_0_valid", 32'(out_0_valid), 32'(got.out_0_valid));
            check("out_1_valid", 32'(out_1_valid), 32'(got.out_1_valid));
            check("pair_out",    32'(pair_out),    32'(got.pair_out));
            check("pair_valid",  32'(pair_valid),  32'(got.pair_valid));
            check("pair_count",  32'(pair_count),  32'(got.pair_count));
            check("seq_error",   32'(seq_error),   32'(got.seq_error));
        end
    endtask

    initial begin
        logic [WIDTH-1:0] xw;
        xw       = 'x;
        rst      = 1'b1;
        in_valid = 1'b0;
        sel      = 1'b0;
        in_word  = '0;
        m_wait_1 = 1'b0;
        m_out_0  = '0;
        m_out_1  = '0;
        m_pair   = '0;
        m_cnt    = '0;

        // 1: reset, then a single ch0 word
        step(1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 4'hF);
        step(1'b0, 1'b1, 1'b0, 4'b1010);
        check("t1_out_0", 32'(out_0), 32'h0000000A);

        // 2: normal pair
        step(1'b0, 1'b1, 1'b0, 4'b0101);
        step(1'b0, 1'b1, 1'b1, 4'b1010);
        check("t2_pair_out", 32'(pair_out), 32'h000000A5);
        check("t2_count",    32'(pair_count), 32'd1);

        // 3: ch1 word while expecting ch0, then a good pair
        step(1'b0, 1'b1, 1'b1, 4'b1111);
        check("t3_seq_error", 32'(seq_error), 32'd1);
        step(1'b0, 1'b1, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 1'b1, 4'b1111);
        check("t3_pair_out", 32'(pair_out), 32'h000000F0);

        // 4: repeated ch0 replaces the pending word
        step(1'b0, 1'b1, 1'b0, 4'b1100);
        step(1'b0, 1'b1, 1'b0, 4'b0011);
        step(1'b0, 1'b1, 1'b1, 4'b1100);
        check("t4_pair_out", 32'(pair_out), 32'h000000C3);

        // 5: 16 pairs from a clean count with idle gaps carrying X data
        step(1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 4'(i));
            step(1'b0, 1'b0, 1'b1, xw);
            step(1'b0, 1'b1, 1'b1, 4'(15 - i));
            step(1'b0, 1'b0, 1'b0, xw);
        end
        check("t5_wrap", 32'(pair_count), 32'd0);

        // 6: reset mid-pair discards the pending ch0 word
        step(1'b0, 1'b1, 1'b0, 4'h6);
        step(1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 4'h9);
        check("t6_seq_error",  32'(seq_error),  32'd1);
        check("t6_pair_valid", 32'(pair_valid), 32'd0);

        // Random traffic, including back-to-back words and occasional reset
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
